// File: rtl/float_recip_fixup.sv
// float_recip_fixup: post-processing stage for the pipelined float reciprocal core.
// Classifies each operand on entry, carries its class through a delay line that
// matches the core latency, then substitutes special/exact results and raises
// per-result and sticky exception flags. Also provides the valid qualification.
module float_recip_fixup #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int RECIP_LATENCY = 11,
    localparam int FLOAT_SIZE   = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    input  logic [FLOAT_SIZE-1:0] s_data,
    input  logic [FLOAT_SIZE-1:0] r_data,
    input  logic                  clear_flags,
    output logic                  m_valid,
    output logic [FLOAT_SIZE-1:0] m_data,
    output logic                  m_dz,
    output logic                  m_inv,
    output logic                  m_uf,
    output logic                  flag_dz,
    output logic                  flag_inv,
    output logic                  flag_uf
);

    localparam int BIAS = 2 ** (EXPONENT_SIZE - 1) - 1;
    localparam int unsigned LAST = RECIP_LATENCY - 1;
    localparam logic [EXPONENT_SIZE:0]   TWO_BIAS    = (EXPONENT_SIZE + 1)'(2 * BIAS);
    localparam logic [EXPONENT_SIZE:0]   TWO_BIAS_M1 = (EXPONENT_SIZE + 1)'(2 * BIAS - 1);
    localparam logic [EXPONENT_SIZE-1:0] EXP_MAX     = '1;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_INF    = 3'd1,
        CLS_NAN    = 3'd2,
        CLS_POW2   = 3'd3,
        CLS_TINY   = 3'd4,
        CLS_NORMAL = 3'd5
    } cls_t;

    logic [EXPONENT_SIZE-1:0] in_exp;
    logic [EXPONENT_SIZE:0]   in_exp_w;
    logic [MANTISSA_SIZE-1:0] in_man;
    cls_t                     in_cls;
    logic                     in_snan;
    logic [EXPONENT_SIZE-1:0] in_pexp;

    logic                     st_valid [RECIP_LATENCY];
    cls_t                     st_cls   [RECIP_LATENCY];
    logic                     st_snan  [RECIP_LATENCY];
    logic                     st_sign  [RECIP_LATENCY];
    logic [EXPONENT_SIZE-1:0] st_exp   [RECIP_LATENCY];

    logic [EXPONENT_SIZE:0]   res_exp_w;
    logic                     unused_exp_msb;
    logic [FLOAT_SIZE-1:0]    nx_data;
    logic                     nx_dz;
    logic                     nx_inv;
    logic                     nx_uf;

    assign in_exp   = s_data[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    assign in_man   = s_data[MANTISSA_SIZE-1:0];
    assign in_exp_w = {1'b0, in_exp};

    // Entry classification; branch order gives first-match priority.
    always_comb begin
        in_cls  = CLS_NORMAL;
        in_snan = 1'b0;
        in_pexp = '0;
        if (in_exp == '0) begin
            in_cls = CLS_ZERO;
        end else if (in_exp == EXP_MAX) begin
            if (in_man == '0) begin
                in_cls = CLS_INF;
            end else begin
                in_cls  = CLS_NAN;
                in_snan = ~in_man[MANTISSA_SIZE-1];
            end
        end else if (in_man == '0 && in_exp_w <= TWO_BIAS_M1) begin
            in_cls  = CLS_POW2;
            in_pexp = in_exp;
        end else if (in_exp_w >= TWO_BIAS || (in_exp_w == TWO_BIAS_M1 && in_man != '0)) begin
            in_cls = CLS_TINY;
        end
    end

    // Delay line aligned with the reciprocal core; shifts every clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < RECIP_LATENCY; i++) begin
                st_valid[i] <= 1'b0;
                st_cls[i]   <= CLS_ZERO;
                st_snan[i]  <= 1'b0;
                st_sign[i]  <= 1'b0;
                st_exp[i]   <= '0;
            end
        end else begin
            st_valid[0] <= s_valid;
            st_cls[0]   <= in_cls;
            st_snan[0]  <= in_snan;
            st_sign[0]  <= s_data[FLOAT_SIZE-1];
            st_exp[0]   <= in_pexp;
            for (int unsigned i = 1; i < RECIP_LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_cls[i]   <= st_cls[i-1];
                st_snan[i]  <= st_snan[i-1];
                st_sign[i]  <= st_sign[i-1];
                st_exp[i]   <= st_exp[i-1];
            end
        end
    end

    // POW2 operands keep this in 1..2*BIAS-1, so the extra MSB is always zero.
    assign res_exp_w      = TWO_BIAS - {1'b0, st_exp[LAST]};
    assign unused_exp_msb = res_exp_w[EXPONENT_SIZE];

    // Result selection from the last delay stage and the core output.
    always_comb begin
        nx_data = r_data;
        nx_dz   = 1'b0;
        nx_inv  = 1'b0;
        nx_uf   = 1'b0;
        case (st_cls[LAST])
            CLS_ZERO: begin
                nx_data = {st_sign[LAST], EXP_MAX, {MANTISSA_SIZE{1'b0}}};
                nx_dz   = 1'b1;
            end
            CLS_INF: begin
                nx_data = {st_sign[LAST], {(FLOAT_SIZE-1){1'b0}}};
            end
            CLS_NAN: begin
                nx_data = {st_sign[LAST], EXP_MAX, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};
                nx_inv  = st_snan[LAST];
            end
            CLS_POW2: begin
                nx_data = {st_sign[LAST], res_exp_w[EXPONENT_SIZE-1:0], {MANTISSA_SIZE{1'b0}}};
            end
            CLS_TINY: begin
                nx_data = {st_sign[LAST], {(FLOAT_SIZE-1){1'b0}}};
                nx_uf   = 1'b1;
            end
            default: ;
        endcase
    end

    // Output register; data and per-result flags update regardless of valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_dz    <= 1'b0;
            m_inv   <= 1'b0;
            m_uf    <= 1'b0;
        end else begin
            m_valid <= st_valid[LAST];
            m_data  <= nx_data;
            m_dz    <= nx_dz;
            m_inv   <= nx_inv;
            m_uf    <= nx_uf;
        end
    end

    // Sticky flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flag_dz  <= 1'b0;
            flag_inv <= 1'b0;
            flag_uf  <= 1'b0;
        end else begin
            flag_dz  <= (m_valid && m_dz)  ? 1'b1 : (clear_flags ? 1'b0 : flag_dz);
            flag_inv <= (m_valid && m_inv) ? 1'b1 : (clear_flags ? 1'b0 : flag_inv);
            flag_uf  <= (m_valid && m_uf)  ? 1'b1 : (clear_flags ? 1'b0 : flag_uf);
        end
    end

endmodule

// File: doc/float_recip_fixup.md
Name: float_recip_fixup

Overview:
- Post-processing stage placed directly downstream of the pipelined float reciprocal unit.
- It tags each operand on entry and tracks its class and valid bit through a delay line matched to the reciprocal latency.
- On exit it muxes in IEEE special-case results and exact power-of-two results, flushes results that fall below the normal range, and raises sticky exception flags.
- Adds the valid qualification that the reciprocal core lacks.

Parameters:
- MANTISSA_SIZE, 23, mantissa bits of operand and result.
- EXPONENT_SIZE, 8, exponent bits. BIAS = 2^(EXPONENT_SIZE-1)-1 and EMAX = 2^EXPONENT_SIZE-1 are derived.
- RECIP_LATENCY, 11, clocks from the operand on s_data to the matching result on r_data.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_valid  in  1  operand valid. Accepted every cycle, no backpressure.
- s_data  in  FLOAT_SIZE  operand. The same value is wired in parallel to the reciprocal core input.
- r_data  in  FLOAT_SIZE  reciprocal core output, RECIP_LATENCY clocks after s_data.
- clear_flags  in  1  synchronous clear of the sticky flags.
- m_valid  out  1  result valid.
- m_data  out  FLOAT_SIZE  final result.
- m_dz  out  1  per-result divide-by-zero indication.
- m_inv  out  1  per-result invalid indication (signaling NaN).
- m_uf  out  1  per-result underflow (flushed) indication.
- flag_dz  out  1  sticky divide-by-zero flag.
- flag_inv  out  1  sticky invalid flag.
- flag_uf  out  1  sticky underflow flag.

Behaviour:
- Reset: async assert while resetn=0.
  - All delay-line valid bits, m_valid, m_data, m_dz, m_inv, m_uf and the sticky flags go to 0.
  - Delay-line class/data registers also reset to 0.
- Classify s_data combinationally on entry (e = exponent, f = mantissa); first match wins:
  - ZERO: e==0. Denormals are flushed and treated as zero.
  - INF: e==EMAX, f==0.
  - NAN: e==EMAX, f!=0. The sNaN sub-flag is set when the mantissa MSB is 0.
  - POW2: f==0 and e<=2*BIAS-1.
  - TINY: e>=2*BIAS, or (e==2*BIAS-1 and f!=0). The true result would be subnormal.
  - NORMAL: everything else.
- Delay line: RECIP_LATENCY stages, shifted every clock unconditionally.
  - Each stage carries valid, class (3 bits), sNaN, sign, and exponent (for POW2 only).
  - Stage RECIP_LATENCY output aligns with r_data.
- Output register (1 clock; total latency RECIP_LATENCY+1 = 12 by default). Driven from the last stage:
  - ZERO: {sign, EMAX, 0}; m_dz=1.
  - INF: {sign, 0, 0}.
  - NAN: {sign, EMAX, 1 followed by zeros} (quieted); m_inv = sNaN.
  - POW2: {sign, 2*BIAS - e, 0}. This is exact and independent of r_data.
  - TINY: {sign, 0, 0}; m_uf=1.
  - NORMAL: r_data passed unchanged.
- m_valid equals the last-stage valid.
  - m_data and the per-result flags update every clock regardless of valid.
  - They are only meaningful while m_valid=1.
- Sticky flags: each flag sets when m_valid and the matching per-result flag are both 1 in the same cycle.
  - clear_flags=1 clears all flags on the next edge.
  - If a set and a clear land in the same cycle, the set wins.
- Streaming: one operand per clock, full throughput.
  - Bubbles (s_valid=0) propagate as m_valid=0 exactly RECIP_LATENCY+1 clocks later.
- Reset mid-operation: all in-flight operands are discarded.
  - The reciprocal core is not reset, so r_data may carry stale values.
  - These are masked because the valid bits are 0.
  - The first operand accepted after deassertion emerges 12 clocks later with the correct value.
- Arithmetic: exponent math is done in EXPONENT_SIZE+1 bits. POW2 guarantees 2*BIAS - e lies in the range 1..2*BIAS-1.

Test Plan:
- Basic path: s_data=0x40000000 (2.0), POW2 → m_data=0x3F000000 at +12 clocks, m_valid=1, all flags 0. Also s_data=0x3FC00000 (1.5), NORMAL, with r_data forced to 0x3F2AAAAB at +11 → m_data=0x3F2AAAAB at +12.
- Zero/inf: 0x00000000 → 0x7F800000 with m_dz=1 and flag_dz set. 0x80000001 (negative denormal) → 0xFF800000. 0xFF800000 → 0x80000000.
- NaN: 0x7F800001 (sNaN) → 0x7FC00000 with m_inv=1. 0xFFC00000 (qNaN) → 0xFFC00000 with m_inv=0.
- Range edges: 0x7E800000 (e=253, f=0) → 0x00800000, uf=0. 0x7E800001 → 0x00000000 with m_uf=1. 0x7F000000 → 0x00000000 with m_uf=1. 0x00800000 → 0x7E800000.
- Streaming and flags: 20 back-to-back operands with bubbles at cycles 5 and 6 → results in order with identical gaps. Assert clear_flags in the same cycle a ZERO result exits → flag_dz remains 1. Assert clear_flags on a cycle with no events → flag_dz goes to 0.
- Reset: pull resetn low for 2 clocks while 8 operands are in flight → all outputs are 0 immediately, and no m_valid appears for those operands. A new operand issued after release → correct result 12 clocks later.
